vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator for the 640x480@60 Hz display path. Runs from the ~25 MHz pixel clock, walks horizontal and vertical position counters through active/front-porch/sync/back-porch phases, and drives the registered x, y, frame_active, hsync and vsync signals consumed directly by graphics_engine. Also provides line/frame start strobes and an optional frame counter for animation.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)

- clk  in  1  pixel clock
- rst_n  in  1  reset: rst_n, synchronous, active-low
- ena  in  1  pixel enable; 0 freezes all state and outputs
- x  out  10  horizontal position
- y  out  9  vertical position, low 9 bits of line count
- frame_active  out  1  1 inside the visible 640x480 window
- hsync  out  1  horizontal sync at SYNC_POL level when asserted
- vsync  out  1  vertical sync at SYNC_POL level when asserted
- line_start  out  1  one-clock strobe at h position 0
- frame_start  out  1  one-clock strobe at h=0, v=0
- frame_ctr  out  10  frames completed (see Configuration)

## Operation
- Internal h_cnt 10 bits (0..H_TOTAL-1, H_TOTAL=800), v_cnt 10 bits (0..V_TOTAL-1, V_TOTAL=525).
- Per-axis phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Horizontal transitions at h_cnt = H_ACTIVE, H_ACTIVE+H_FP, +H_SYNC, and wrap; vertical likewise on v_cnt. Phase is derived from or kept consistent with the counter; mismatch is a bug.
- When ena=1: h_cnt increments; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap returns to 0.
- Decode (from counters): hact = h_cnt<640; vact = v_cnt<480; hs = 656<=h_cnt<=751; vs = 490<=v_cnt<=491.
- Outputs registered from the decode: x=h_cnt, y=v_cnt[8:0] (lines 512..524 alias to 0..12; consumers gate with frame_active), frame_active=hact&vact, hsync=hs?SYNC_POL:~SYNC_POL, vsync likewise, line_start=(h_cnt==0), frame_start=(h_cnt==0 && v_cnt==0).
- Reset (rst_n=0 at clk edge, takes priority over ena): h_cnt=v_cnt=0, phases ACTIVE, x=0, y=0, frame_active=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0, frame_ctr=0. Reset mid-frame aborts immediately; no partial sync pulse completes.
- ena=0: counters, FSMs and all outputs (including strobes) hold; a strobe held high stays high until next ena=1 cycle.

## Timing
- Output latency: 1 enabled clock after counter value; all outputs mutually aligned.
- First enabled clock after reset: outputs show h=0,v=0 (frame_active=1, line_start=1, frame_start=1).
- hsync asserted exactly 96 enabled clocks per line; vsync exactly 2 lines (1600 clocks) per frame, edges coincident with h wrap.
- Line period 800 clocks, frame period 420000 clocks.

## Configuration
- VGA_TIMING_FRAME_CTR_EN defined: 10-bit frame_ctr increments (mod 1024) on the same enabled clock frame_start is registered high, except the first after reset (counts completed frames).
- Undefined: counter logic absent; frame_ctr tied to 0.

## Test plan
- Reset then ena=1 continuous -> clock 1: x=0,y=0,frame_active=1,line_start=1,frame_start=1; clock 641: x=640, frame_active=0.
- Horizontal sync -> hsync low for x=656..751 (96 clocks), high at x=752; line_start period 800.
- Vertical sync -> vsync low for lines 490..491 only; y=0 again 420000 clocks after first frame_start; y reads 0..12 on lines 512..524 with frame_active=0.
- ena toggled 1/0 every clock -> all timings stretch exactly 2x; outputs unchanged during ena=0 cycles.
- rst_n pulsed at x=700,y=491 (vsync low) -> next clock vsync=hsync=1, x=0,y=0 outputs cleared; next enabled clock restarts at frame_start.
- With VGA_TIMING_FRAME_CTR_EN -> frame_ctr=0 after first frame_start, 3 after 3 full frames, wraps 1023->0; without macro stays 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel timing generator: position counters, phase FSMs, registered sync/position outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CTR_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frame_active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_ctr
);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_END = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_END = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  phase_t     r_hph, w_hph_nxt, r_vph, w_vph_nxt;
  logic [9:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  logic       w_h_wrap, w_v_wrap;
  logic       w_hact, w_vact, w_hs, w_vs;
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic       r_fa, r_hsync, r_vsync, r_ls, r_fs;

  always_comb begin
    w_h_wrap = (r_h_cnt == H_END);
    w_v_wrap = (r_v_cnt == V_END);
    w_h_nxt  = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) w_v_nxt = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
  end

  // Phases advance on the counter value they are about to enter, so phase always matches count.
  always_comb begin
    w_hph_nxt = r_hph;
    case (r_hph)
      PH_ACTIVE: if (w_h_nxt == H_ACT) w_hph_nxt = PH_FRONT;
      PH_FRONT:  if (w_h_nxt == H_SS)  w_hph_nxt = PH_SYNC;
      PH_SYNC:   if (w_h_nxt == H_SE)  w_hph_nxt = PH_BACK;
      PH_BACK:   if (w_h_wrap)         w_hph_nxt = PH_ACTIVE;
      default:                         w_hph_nxt = PH_ACTIVE;
    endcase
  end

  always_comb begin
    w_vph_nxt = r_vph;
    if (w_h_wrap) begin
      case (r_vph)
        PH_ACTIVE: if (w_v_nxt == V_ACT) w_vph_nxt = PH_FRONT;
        PH_FRONT:  if (w_v_nxt == V_SS)  w_vph_nxt = PH_SYNC;
        PH_SYNC:   if (w_v_nxt == V_SE)  w_vph_nxt = PH_BACK;
        PH_BACK:   if (w_v_wrap)         w_vph_nxt = PH_ACTIVE;
        default:                         w_vph_nxt = PH_ACTIVE;
      endcase
    end
  end

  always_comb begin
    w_hact = (r_hph == PH_ACTIVE);
    w_vact = (r_vph == PH_ACTIVE);
    w_hs   = (r_hph == PH_SYNC);
    w_vs   = (r_vph == PH_SYNC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hph   <= PH_ACTIVE;
      r_vph   <= PH_ACTIVE;
      r_x     <= '0;
      r_y     <= '0;
      r_fa    <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else if (ena) begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_hph   <= w_hph_nxt;
      r_vph   <= w_vph_nxt;
      r_x     <= r_h_cnt;
      r_y     <= r_v_cnt[8:0];
      r_fa    <= w_hact & w_vact;
      r_hsync <= w_hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs ? SYNC_POL : ~SYNC_POL;
      r_ls    <= (r_h_cnt == 10'd0);
      r_fs    <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    end
  end

`ifdef VGA_TIMING_FRAME_CTR_EN
  logic [9:0] r_frame_ctr;
  logic       r_seen;
  // The first frame_start after reset opens frame 0; later ones close a completed frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_ctr <= '0;
      r_seen      <= 1'b0;
    end else if (ena && r_h_cnt == 10'd0 && r_v_cnt == 10'd0) begin
      if (r_seen) r_frame_ctr <= r_frame_ctr + 10'd1;
      r_seen <= 1'b1;
    end
  end
  assign frame_ctr = r_frame_ctr;
`else
  assign frame_ctr = '0;
`endif

  assign x            = r_x;
  assign y            = r_y;
  assign frame_active = r_fa;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign line_start   = r_ls;
  assign frame_start  = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: instance 0 uses default 640x480 timing, instance 1 a short line
// (15 clocks, 525 lines) so whole frames fit in the run. Both are checked every clock via a scoreboard.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] x0, x1, c0, c1;
  logic [8:0] y0, y1;
  logic fa0, fa1, hs0, hs1, vs0, vs1, ls0, ls1, fs0, fs1;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(x0), .y(y0), .frame_active(fa0),
    .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0), .frame_ctr(c0));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(x1), .y(y1), .frame_active(fa1),
    .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1), .frame_ctr(c1));

  int P_HA[2] = '{640, 8};
  int P_HF[2] = '{16, 2};
  int P_HS[2] = '{96, 3};
  int P_HT[2] = '{800, 15};
  localparam int VA = 480, VF = 10, VS = 2, VT = 525;

  int         mh[2], mv[2];
  logic [9:0] mctr[2];
  bit         mseen[2];
  logic [33:0] last[2];
  logic [33:0] q0[$], q1[$];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [33:0] dec(int i);
    logic hact, vact, hs, vs, ls, fs;
    hact = mh[i] < P_HA[i];
    vact = mv[i] < VA;
    hs   = (mh[i] >= P_HA[i] + P_HF[i]) && (mh[i] < P_HA[i] + P_HF[i] + P_HS[i]);
    vs   = (mv[i] >= VA + VF) && (mv[i] < VA + VF + VS);
    ls   = (mh[i] == 0);
    fs   = (mh[i] == 0) && (mv[i] == 0);
    return {10'(mh[i]), 9'(mv[i]), hact & vact, ~hs, ~vs, ls, fs, mctr[i]};
  endfunction

  task automatic model_step(input bit r, input bit e);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        mh[i] = 0; mv[i] = 0; mctr[i] = '0; mseen[i] = 1'b0;
        last[i] = {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
      end else if (e) begin
`ifdef VGA_TIMING_FRAME_CTR_EN
        if (mh[i] == 0 && mv[i] == 0) begin
          if (mseen[i]) mctr[i] = mctr[i] + 10'd1;
          mseen[i] = 1'b1;
        end
`endif
        last[i] = dec(i);
        if (mh[i] == P_HT[i] - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == VT - 1) ? 0 : mv[i] + 1;
        end else mh[i] = mh[i] + 1;
      end
    end
    q0.push_back(last[0]);
    q1.push_back(last[1]);
  endtask

  // line/frame measurement, active only while ena is held high
  bit meas = 0;
  int h_lo = 0, l_per = 0, f_per = 0;
  bit l_seen = 0, f_seen = 0;

  task automatic cyc(input bit r, input bit e);
    logic [33:0] e0, e1;
    rst_n = r;
    ena = e;
    model_step(r, e);
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("outs0", {x0, y0, fa0, hs0, vs0, ls0, fs0, c0}, e0);
    check("outs1", {x1, y1, fa1, hs1, vs1, ls1, fs1, c1}, e1);
    if (meas) begin
      if (ls0) begin
        if (l_seen) begin
          check("hsync_width", h_lo, 96);
          check("line_period", l_per, 800);
        end
        l_seen = 1; h_lo = 0; l_per = 0;
      end
      if (!hs0) h_lo++;
      l_per++;
      if (fs1) begin
        if (f_seen) check("frame_period", f_per, 15 * 525);
        f_seen = 1; f_per = 0;
      end
      f_per++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, 1);
    check("rst_hsync", hs0, 1'b1);
    check("rst_fa", fa0, 1'b0);

    meas = 1;
    cyc(1, 1);
    check("c1_fs", {fa0, ls0, fs0, x0}, {3'b111, 10'd0});
    for (int i = 0; i < 640; i++) cyc(1, 1);
    check("c641", {fa0, x0}, {1'b0, 10'd640});
    for (int i = 0; i < 17000; i++) cyc(1, 1);
    meas = 0;

    for (int i = 0; i < 16000; i++) cyc(1, (i % 2) == 0);

    begin
      bit hit = 0;
      for (int i = 0; i < 8000 && !hit; i++) begin
        if (mv[1] == 491 && mh[1] == 10) hit = 1;
        else cyc(1, 1);
      end
      check("reach_v491", hit, 1'b1);
    end
    check("pre_rst_vs", vs1, 1'b0);
    cyc(0, 1);
    check("rst_mid", {vs1, hs1, x1, y1, fs1}, {2'b11, 10'd0, 9'd0, 1'b0});
    cyc(1, 1);
    check("restart_fs", {fs1, fs0}, 2'b11);
    for (int i = 0; i < 3 * 15 * 525; i++) cyc(1, 1);
    check("fs_3frames", fs1, 1'b1);
`ifdef VGA_TIMING_FRAME_CTR_EN
    check("ctr3", c1, 10'd3);
`else
    check("ctr0", c1, 10'd0);
`endif
    for (int i = 0; i < 20; i++) cyc(1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
